// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light sensor aggregator: lane indices,
// congestion level encoding, debounce FSM state encoding and the quantizer.
package tlc_pkg;

    localparam int WEST      = 0;
    localparam int SOUTH     = 1;
    localparam int EAST      = 2;
    localparam int NORTH     = 3;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        LVL_NONE = 2'b00,
        LVL_LOW  = 2'b01,
        LVL_MED  = 2'b10,
        LVL_HIGH = 2'b11
    } level_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_ARMING  = 2'b01,
        ST_PRESENT = 2'b10,
        ST_LEAVING = 2'b11
    } lane_state_t;

    // Map an arrival count onto a congestion level using three ascending thresholds.
    function automatic level_t quantize(
        input logic [31:0] c,
        input logic [31:0] t1,
        input logic [31:0] t2,
        input logic [31:0] t3
    );
        level_t lvl;
        if (c < t1) begin
            lvl = LVL_NONE;
        end else if (c < t2) begin
            lvl = LVL_LOW;
        end else if (c < t3) begin
            lvl = LVL_MED;
        end else begin
            lvl = LVL_HIGH;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/tlc_lane_detect.sv
// One loop-detector lane: 2-flop synchronizer, four-state debounce FSM that
// emits an arrival on ARMING->PRESENT, and a saturating arrival counter that
// is cleared by green feedback or by the window boundary.
module tlc_lane_detect
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_b,
    input  logic             i_loop,
    input  logic             i_green,
    input  logic             i_win_clr,
    output logic [CNT_W-1:0] o_snap
);

    localparam logic [3:0]       DB_LAST = 4'(DEBOUNCE - 1);
    localparam bit               DB_ONE  = (DEBOUNCE == 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_sync1;
    logic             r_sync2;
    lane_state_t      r_state;
    logic [3:0]       r_db_cnt;
    logic [CNT_W-1:0] r_cnt;

    lane_state_t      w_state_nxt;
    logic [3:0]       w_db_nxt;
    logic             w_arrival;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_snap;

    // Two-stage synchronizer for the asynchronous loop input.
    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_loop;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state logic; r_db_cnt counts consecutive samples of the new level.
    always_comb begin
        w_state_nxt = r_state;
        w_db_nxt    = r_db_cnt;
        w_arrival   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (r_sync2) begin
                    if (DB_ONE) begin
                        w_state_nxt = ST_PRESENT;
                        w_db_nxt    = 4'd0;
                        w_arrival   = 1'b1;
                    end else begin
                        w_state_nxt = ST_ARMING;
                        w_db_nxt    = 4'd1;
                    end
                end else begin
                    w_db_nxt = 4'd0;
                end
            end
            ST_ARMING: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_EMPTY;
                    w_db_nxt    = 4'd0;
                end else if (r_db_cnt >= DB_LAST) begin
                    w_state_nxt = ST_PRESENT;
                    w_db_nxt    = 4'd0;
                    w_arrival   = 1'b1;
                end else begin
                    w_db_nxt = r_db_cnt + 4'd1;
                end
            end
            ST_PRESENT: begin
                if (!r_sync2) begin
                    w_state_nxt = DB_ONE ? ST_EMPTY : ST_LEAVING;
                    w_db_nxt    = DB_ONE ? 4'd0 : 4'd1;
                end else begin
                    w_db_nxt = 4'd0;
                end
            end
            ST_LEAVING: begin
                if (r_sync2) begin
                    w_state_nxt = ST_PRESENT;
                    w_db_nxt    = 4'd0;
                end else if (r_db_cnt >= DB_LAST) begin
                    w_state_nxt = ST_EMPTY;
                    w_db_nxt    = 4'd0;
                end else begin
                    w_db_nxt = r_db_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_db_nxt    = 4'd0;
            end
        endcase
    end

    // Debounce FSM state registers.
    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_state  <= ST_EMPTY;
            r_db_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_nxt;
        end
    end

    // Count value as seen at this edge: green wins over a same-cycle arrival.
    always_comb begin
        w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (i_green) begin
            w_snap = '0;
        end else if (w_arrival) begin
            w_snap = w_cnt_inc;
        end else begin
            w_snap = r_cnt;
        end
    end

    // Arrival counter; the window boundary restarts it after the snapshot is taken.
    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_cnt <= '0;
        end else if (i_win_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_snap;
        end
    end

    assign o_snap = w_snap;

endmodule

// File: rtl/tlc_sensor_agg.sv
// Sensor aggregator: four lane detectors, a free-running sampling window,
// and per-lane quantized congestion levels registered at each window boundary.
module tlc_sensor_agg
    import tlc_pkg::*;
#(
    parameter int WINDOW_CYCLES = 30,
    parameter int DEBOUNCE      = 3,
    parameter int CNT_W         = 8,
    parameter int THR1          = 1,
    parameter int THR2          = 3,
    parameter int THR3          = 6
) (
    input  logic       i_clock,
    input  logic       i_reset_b,
    input  logic [3:0] i_loop,
    input  logic [3:0] i_green,
    output logic [1:0] o_w_sensor,
    output logic [1:0] o_s_sensor,
    output logic [1:0] o_e_sensor,
    output logic [1:0] o_n_sensor,
    output logic       o_valid
);

    localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

    logic [15:0]      r_win;
    logic             w_boundary;
    logic [CNT_W-1:0] w_snap [NUM_LANES];
    level_t           r_lvl  [NUM_LANES];
    logic             r_valid;

    assign w_boundary = (r_win == WIN_LAST);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tlc_lane_detect #(
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_lane (
            .i_clock   (i_clock),
            .i_reset_b (i_reset_b),
            .i_loop    (i_loop[g]),
            .i_green   (i_green[g]),
            .i_win_clr (w_boundary),
            .o_snap    (w_snap[g])
        );
    end

    // Sampling window counter, 0..WINDOW_CYCLES-1 then wrap.
    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_win <= 16'd0;
        end else if (w_boundary) begin
            r_win <= 16'd0;
        end else begin
            r_win <= r_win + 16'd1;
        end
    end

    // Capture quantized levels and raise the one-cycle valid strobe at the boundary.
    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                r_lvl[n] <= LVL_NONE;
            end
            r_valid <= 1'b0;
        end else if (w_boundary) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                r_lvl[n] <= quantize(32'(w_snap[n]), 32'(THR1), 32'(THR2), 32'(THR3));
            end
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_w_sensor = r_lvl[WEST];
    assign o_s_sensor = r_lvl[SOUTH];
    assign o_e_sensor = r_lvl[EAST];
    assign o_n_sensor = r_lvl[NORTH];
    assign o_valid    = r_valid;

endmodule

// File: tb/tb_tlc_sensor_agg.sv
// Directed bench for tlc_sensor_agg: a default instance (30-cycle window)
// for window timing and reset behaviour, and a long-window 3-bit-counter
// instance driven from a table of per-window pulse patterns.
module tb_tlc_sensor_agg;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [3:0] loop_a, green_a, loop_b, green_b;
    logic [1:0] a_w, a_s, a_e, a_n, b_w, b_s, b_e, b_n;
    logic       a_valid, b_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlc_sensor_agg u_dut_a (
        .i_clock(clk), .i_reset_b(rst_b), .i_loop(loop_a), .i_green(green_a),
        .o_w_sensor(a_w), .o_s_sensor(a_s), .o_e_sensor(a_e), .o_n_sensor(a_n),
        .o_valid(a_valid)
    );

    tlc_sensor_agg #(.WINDOW_CYCLES(200), .CNT_W(3)) u_dut_b (
        .i_clock(clk), .i_reset_b(rst_b), .i_loop(loop_b), .i_green(green_b),
        .o_w_sensor(b_w), .o_s_sensor(b_s), .o_e_sensor(b_e), .o_n_sensor(b_n),
        .o_valid(b_valid)
    );

    typedef struct {
        int         n_w, n_s, n_e, n_n;   // clean pulses (high 5, low 5) from cycle 0
        int         glitch_s;             // south held high for this many cycles from cycle 0
        bit         late_w;               // west high in cycles 195..199 (arrival on boundary)
        logic [3:0] g_mask;               // green lanes
        int         g_cyc;                // cycle of the one-cycle green, -1 for none
        logic [1:0] e_w, e_s, e_e, e_n;   // expected levels after the boundary
    } vec_t;

    vec_t tbl [13];

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pulse_at(input int n, input int c);
        return ((c / 10) < n) && ((c % 10) < 5);
    endfunction

    // Wait (bounded) until the selected instance shows o_valid at a negedge.
    task automatic wait_valid(input bit sel_b, input int budget, input string name);
        int k;
        k = 0;
        while (((sel_b ? b_valid : a_valid) !== 1'b1) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk1(name, sel_b ? b_valid : a_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          w   s  e  n  gl late gmask   gcyc  ew     es     ee     en
        tbl[0]  = '{7,  0, 2, 3, 0, 1'b0, 4'b0000, -1,  2'b11, 2'b00, 2'b01, 2'b10};
        tbl[1]  = '{12, 1, 5, 6, 0, 1'b0, 4'b0000, -1,  2'b11, 2'b01, 2'b10, 2'b11};
        tbl[2]  = '{0,  0, 0, 0, 0, 1'b0, 4'b0000, -1,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{2,  0, 0, 4, 0, 1'b0, 4'b1000, 198, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[4]  = '{0,  0, 6, 4, 0, 1'b0, 4'b1000, 199, 2'b00, 2'b00, 2'b11, 2'b00};
        tbl[5]  = '{0,  3, 0, 4, 0, 1'b0, 4'b0000, -1,  2'b00, 2'b10, 2'b00, 2'b10};
        tbl[6]  = '{1,  0, 0, 0, 0, 1'b0, 4'b0001, 4,   2'b00, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{1,  0, 0, 0, 0, 1'b0, 4'b0001, 3,   2'b01, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{0,  0, 0, 0, 0, 1'b1, 4'b0000, -1,  2'b01, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{0,  0, 0, 0, 0, 1'b0, 4'b0000, -1,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{8,  0, 0, 0, 0, 1'b0, 4'b0000, -1,  2'b11, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{0,  0, 0, 0, 2, 1'b0, 4'b0000, -1,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[12] = '{0,  0, 0, 0, 3, 1'b0, 4'b0000, -1,  2'b00, 2'b01, 2'b00, 2'b00};

        rst_b   = 1'b0;
        loop_a  = 4'b0000;
        green_a = 4'b0000;
        loop_b  = 4'b0000;
        green_b = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        chk1("rst_valid_a", a_valid, 1'b0);
        chk2("rst_w_a", a_w, 2'b00);
        chk2("rst_s_a", a_s, 2'b00);
        chk2("rst_e_a", a_e, 2'b00);
        chk2("rst_n_a", a_n, 2'b00);
        chk1("rst_valid_b", b_valid, 1'b0);
        chk2("rst_w_b", b_w, 2'b00);
        chk2("rst_n_b", b_n, 2'b00);

        // Idle windows: o_valid exactly at edges 30, 60, 90 after release.
        rst_b = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            @(negedge clk);
            chk1("idle_valid_a", a_valid, (k % 30) == 0);
            if ((k % 30) == 0) begin
                chk2("idle_w_a", a_w, 2'b00);
                chk2("idle_s_a", a_s, 2'b00);
                chk2("idle_e_a", a_e, 2'b00);
                chk2("idle_n_a", a_n, 2'b00);
            end
        end

        // Two west arrivals in one 30-cycle window -> level 01.
        wait_valid(1'b0, 40, "align_a");
        for (int c = 0; c < 30; c++) begin
            loop_a[WEST] = pulse_at(2, c);
            @(negedge clk);
        end
        chk1("win2_valid_a", a_valid, 1'b1);
        chk2("win2_w_a", a_w, 2'b01);
        chk2("win2_e_a", a_e, 2'b00);

        // Reset mid-window with two arrivals pending.
        for (int c = 0; c < 15; c++) begin
            loop_a[WEST] = pulse_at(2, c);
            @(negedge clk);
        end
        loop_a = 4'b0000;
        #2;
        rst_b = 1'b0;
        #1;
        chk2("async_rst_w_a", a_w, 2'b00);
        chk1("async_rst_valid_a", a_valid, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;

        // Full window after release, one post-reset west arrival -> 01.
        for (int c = 0; c < 30; c++) begin
            loop_a[WEST] = pulse_at(1, c);
            @(negedge clk);
            if (c == 28) begin
                chk1("post_rst_early_a", a_valid, 1'b0);
            end
        end
        chk1("post_rst_valid_a", a_valid, 1'b1);
        chk2("post_rst_w_a", a_w, 2'b01);
        chk2("post_rst_n_a", a_n, 2'b00);
        loop_a = 4'b0000;

        // Table-driven windows on the long-window 3-bit-counter instance.
        wait_valid(1'b1, 250, "align_b");
        for (int r = 0; r < 13; r++) begin
            for (int c = 0; c < 200; c++) begin
                loop_b[WEST]  = tbl[r].late_w ? (c >= 195) : pulse_at(tbl[r].n_w, c);
                loop_b[SOUTH] = pulse_at(tbl[r].n_s, c) || (c < tbl[r].glitch_s);
                loop_b[EAST]  = pulse_at(tbl[r].n_e, c);
                loop_b[NORTH] = pulse_at(tbl[r].n_n, c);
                green_b       = (c == tbl[r].g_cyc) ? tbl[r].g_mask : 4'b0000;
                @(negedge clk);
                if (c == 198) begin
                    chk1($sformatf("row%0d_pre_valid", r), b_valid, 1'b0);
                end
            end
            chk1($sformatf("row%0d_valid", r), b_valid, 1'b1);
            chk2($sformatf("row%0d_w", r), b_w, tbl[r].e_w);
            chk2($sformatf("row%0d_s", r), b_s, tbl[r].e_s);
            chk2($sformatf("row%0d_e", r), b_e, tbl[r].e_e);
            chk2($sformatf("row%0d_n", r), b_n, tbl[r].e_n);
        end
        loop_b  = 4'b0000;
        green_b = 4'b0000;
        @(negedge clk);
        chk1("valid_one_cycle_b", b_valid, 1'b0);
        chk2("hold_s_b", b_s, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlc_sensor_agg.md
TLC_SENSOR_AGG -- requirements
Module: tlc_sensor_agg

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 30: sampling window length in clock cycles, legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE, default 3: consecutive synchronized samples needed to accept a level change, legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 8: width of the per-lane arrival counter.
REQ-004 SHALL have parameters THR1, THR2, THR3, defaults 1, 3, 6: level thresholds, with THR1 < THR2 < THR3 <= 2^CNT_W-1.
REQ-005 SHALL have port i_clock  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port i_reset_b  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port i_loop  input  4  raw, asynchronous loop-detector inputs, bit order [3]=north, [2]=east, [1]=south, [0]=west.
REQ-008 SHALL have port i_green  input  4  green-lamp feedback from the controller, same bit order; synchronous.
REQ-009 SHALL have ports o_w_sensor, o_s_sensor, o_e_sensor, o_n_sensor  output  2 each  congestion level per lane, feeding the traffic light controller sensor inputs.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse marking a level update.

Function
REQ-011 Each i_loop bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per-lane debounce FSM SHALL have four states, EMPTY, ARMING, PRESENT and LEAVING:
- EMPTY -> ARMING on synchronized 1.
- ARMING -> PRESENT after DEBOUNCE consecutive 1 samples; returns to EMPTY on any 0.
- PRESENT -> LEAVING on 0.
- LEAVING -> EMPTY after DEBOUNCE consecutive 0 samples; returns to PRESENT on any 1.
REQ-013 The ARMING->PRESENT transition SHALL generate one arrival pulse.
- Latency: raw rise held stable gives an arrival pulse in cycle 2+DEBOUNCE after the first sampling edge.
REQ-014 Each arrival SHALL increment that lane's counter by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-015 i_green[n]=1 SHALL clear lane n counter to 0 that cycle; clear beats a same-cycle arrival.
REQ-016 The window counter SHALL run 0..WINDOW_CYCLES-1 and then wrap to 0.
- The cycle where it equals WINDOW_CYCLES-1 is the boundary.
REQ-017 At the boundary edge, each lane snapshot SHALL use the counter value including any same-cycle arrival.
- Green clear overrides: a lane with i_green=1 at the boundary snapshots 0.
- All four counters then reset to 0.
REQ-018 Quantization SHALL map the snapshot count c to a level:
- c < THR1 -> 00
- c < THR2 -> 01
- c < THR3 -> 10
- otherwise -> 11
REQ-019 Level outputs SHALL be registered, update only at the boundary edge, and hold between boundaries.
REQ-020 o_valid SHALL be 1 in exactly the cycle following each boundary edge, coincident with the new levels.
REQ-021 The first o_valid after reset release SHALL occur WINDOW_CYCLES cycles after the first active edge.
REQ-022 Arrivals on different lanes SHALL be independent; simultaneous arrivals on all four lanes SHALL all be counted.

Reset
REQ-023 While i_reset_b=0, all of the following SHALL be forced immediately, without a clock:
- synchronizers to 0
- FSMs to EMPTY
- counters and window counter to 0
- all o_*_sensor to 00
- o_valid to 0
REQ-024 Reset asserted mid-window SHALL discard partial counts; after release, counting SHALL restart a full window.

Structure
REQ-025 Shared package tlc_pkg SHALL hold:
- lane index constants (WEST=0, SOUTH=1, EAST=2, NORTH=3)
- the 2-bit level encoding
- the debounce FSM state encoding
REQ-026 Sub-module tlc_lane_detect SHALL contain synchronizer, debounce FSM, and saturating counter with clear.
- Instantiated four times.
- Window counter, quantizer and output registers live in the top.

Verification
REQ-027 Defaults, no loop activity for 3 windows -> o_valid pulses at cycles 30, 60, 90; all levels 00.
REQ-028 West gets 7 clean pulses (high 5, low 5) in one window, east 2, south 0, north 3 -> after boundary o_w=11, o_e=01, o_s=00, o_n=10.
REQ-029 South glitch high for 2 cycles with DEBOUNCE=3 -> no arrival; o_s_sensor stays 00.
REQ-030 Lane north gets 4 arrivals, then i_green[3]=1 for 1 cycle before the boundary -> o_n_sensor=00.
- Same for i_green asserted on the boundary cycle.
REQ-031 CNT_W=3, 12 arrivals on west in one window -> counter saturates at 7, o_w_sensor=11, no wrap to low level.
REQ-032 i_reset_b driven low mid-window with counts pending -> all outputs 00 immediately.
- After release, the next o_valid arrives a full WINDOW_CYCLES later and reflects only post-reset arrivals.
